// File: rtl/bin_to_bcd_if.sv
// Handshake and result bundle for the binary-to-BCD converter.
// The source drives in_*; the converter drives ready and results.
interface bin_to_bcd_if #(
  parameter int W      = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_data;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     blank;
  logic                  out_valid;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  digits,
    input  blank,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output digits,
    output blank,
    output out_valid
  );
endinterface

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter feeding seven-segment decoders.
// Result registers hold the last value while the next one converts.
module bin_to_bcd #(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic       clk,
  input  logic       reset,
  bin_to_bcd_if.slave bus
);
  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);
  localparam logic [DIGITS-1:0] BLK_RST =
    {DIGITS{1'b1}} << 1;

  function automatic bit fits(
    input int w,
    input int d
  );
    longint unsigned p;
    longint unsigned m;
    p = 64'd1;
    m = (64'd1 << w) - 64'd1;
    for (int i = 0; i < d; i++) begin
      if (p <= m) p = p * 64'd10;
    end
    return p > m;
  endfunction

  if (W < 1 || W > 32) begin : g_w_chk
    $error("bin_to_bcd: W out of range 1..32");
  end

  if (!fits(W, DIGITS)) begin : g_d_chk
    $error("bin_to_bcd: DIGITS too small for W");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    shr_q, shr_d;
  logic [SW-1:0]   scr_q, scr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   dig_q, dig_d;
  logic [DIGITS-1:0] blk_q, blk_d;
  logic            ov_q, ov_d;

  logic [SW-1:0]   adj;
  logic [SW-1:0]   nxt;
  logic [DIGITS-1:0] blk_new;
  logic            zero_run;
  logic            rdy;
  logic            hs;

  // add-3 per nibble, then one-bit shift of {scratch, shr}
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i+:4] >= 4'd5) begin
        adj[4*i+:4] = scr_q[4*i+:4] + 4'd3;
      end else begin
        adj[4*i+:4] = scr_q[4*i+:4];
      end
    end
    nxt = (adj << 1) | SW'(shr_q[W-1]);
  end

  // digit 0 is never blanked so zero shows as "0"
  always_comb begin
    blk_new  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (nxt[4*i+:4] == 4'd0);
      blk_new[i] = zero_run;
    end
  end

  assign rdy = (state_q == IDLE) & ~reset;
  assign hs  = bus.in_valid & rdy;

  always_comb begin
    state_d = state_q;
    shr_d   = shr_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    blk_d   = blk_q;
    ov_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = SHIFT;
          shr_d   = bus.in_data;
          scr_d   = '0;
          cnt_d   = CW'(W);
        end
      end
      SHIFT: begin
        scr_d = nxt;
        shr_d = shr_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          dig_d   = nxt;
          blk_d   = blk_new;
          ov_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shr_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      blk_q   <= BLK_RST;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shr_q   <= shr_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      blk_q   <= blk_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.digits    = dig_q;
  assign bus.blank     = blk_q;
  assign bus.out_valid = ov_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd (W=16, DIGITS=5).
// Checks latency, ready window, hold behaviour and reset abort.
module tb_bin_to_bcd;
  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    logic [19:0] d;
    logic [4:0]  b;
    int          c;
  } exp_t;

  exp_t        sb[$];
  logic [19:0] last_d;
  logic [4:0]  last_b;
  int          free_cyc;

  bin_to_bcd_if #(.W(16), .DIGITS(5)) bus ();

  bin_to_bcd #(.W(16), .DIGITS(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] to_blk(input logic [19:0] d);
    logic [4:0] b;
    logic       z;
    b = '0;
    z = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      z    = z & (d[4*i+:4] == 4'd0);
      b[i] = z;
    end
    return b;
  endfunction

  // per-cycle monitor: ready window, pulse timing, held results
  always @(negedge clk) begin
    exp_t e;
    logic exp_ov;
    if (reset) begin
      check("rst_ready", bus.in_ready, 0);
      sb.delete();
      free_cyc = cyc + 1;
      last_d   = '0;
      last_b   = 5'b11110;
    end else begin
      check("ready", bus.in_ready, cyc >= free_cyc);
      exp_ov = (sb.size() != 0) && (sb[0].c == cyc);
      check("out_valid", bus.out_valid, exp_ov);
      if (exp_ov) begin
        e      = sb.pop_front();
        last_d = e.d;
        last_b = e.b;
      end
      check("digits", bus.digits, last_d);
      check("blank", bus.blank, last_b);
      if (bus.in_valid && bus.in_ready) begin
        e.d = to_bcd(int'(bus.in_data));
        e.b = to_blk(e.d);
        e.c = cyc + 17;
        sb.push_back(e);
        free_cyc = cyc + 18;
      end
    end
  end

  task automatic send(
    input  logic [15:0] v,
    output int          t
  );
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("hs_timeout", 0, 1);
    t = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    int t;
    cyc          = 0;
    checks       = 0;
    errors       = 0;
    free_cyc     = 0;
    last_d       = '0;
    last_b       = 5'b11110;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    send(16'd0, t);
    wait_done();
    send(16'hFFFF, t);
    wait_done();
    send(16'd1234, t);
    wait_done();

    // value offered mid-conversion must be ignored
    send(16'd1234, t);
    while (cyc < t + 5) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd9;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    send(16'd100, t);
    wait_done();

    // reset during cycle T+8 aborts the conversion
    send(16'hFFFF, t);
    while (cyc < t + 8) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    send(16'd42, t);
    wait_done();

    for (int i = 0; i < 8; i++) begin
      send(16'($urandom_range(0, 65535)), t);
      wait_done();
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd.md
# bin_to_bcd

- Sequential double-dabble converter: takes an unsigned binary value and produces packed BCD digits plus a leading-zero blank mask.
- Sits directly upstream of the per-digit seven-segment decoders. Each output nibble feeds one decoder's 4-bit input; each blank bit gates that digit off.
- Result registers hold the last converted value, so the display is stable while the next conversion runs.

## Interface

- W, 16: width of binary input. Legal range is 1..32.
- DIGITS, 5: number of BCD output digits. Must satisfy 10^DIGITS > 2^W − 1; an elaboration-time check fails otherwise. There is no runtime overflow detection.

- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a new value
- in_data  input  W  unsigned binary value
- digits  output  4*DIGITS  packed BCD result; digit i occupies bits [4i+3:4i], digit 0 is least significant
- blank  output  DIGITS  bit i high means digit i is a leading zero and should be blanked
- out_valid  output  1  one-cycle pulse when digits/blank update

One clock; reset is synchronous and active-high.

## Operation

- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0.
  - DONE: in_ready=0.
- IDLE → SHIFT on in_valid & in_ready:
  - Load the shift register from in_data.
  - Clear the BCD scratch register.
  - Set the iteration counter to W.
- SHIFT, each cycle:
  - Every scratch nibble ≥ 5 gets +3 (4-bit add, no carry between nibbles).
  - Then shift {scratch, shift register} left by one.
  - Decrement the counter.
  - Go to DONE when the counter reaches 1, i.e. after exactly W iterations.
- DONE:
  - digits ← scratch.
  - blank recomputed.
  - out_valid=1 for this cycle only.
  - Next state IDLE.
- blank rules:
  - blank[i] = 1 when digit i and every higher digit are zero, for i ≥ 1.
  - blank[0] is always 0, so the value zero displays as a single "0".
- digits and blank change only in DONE or on reset; they hold otherwise.
- in_valid in SHIFT/DONE is ignored. There is no queuing; the source must hold in_valid until a handshake.
- in_data is sampled only on the handshake cycle; later changes have no effect on a conversion in progress.
- Reset values:
  - state IDLE.
  - digits all 0.
  - blank = all ones except bit 0.
  - out_valid 0.
  - scratch and counter 0.
- in_ready is forced to 0 while reset is high.
- reset asserted mid-conversion:
  - Conversion aborted.
  - Outputs go to reset values on that edge.
  - No out_valid.
  - IDLE on the first cycle after reset deasserts.

## Timing

- Handshake at cycle T.
- SHIFT occupies T+1..T+W.
- DONE at T+W+1: digits/blank are visible and out_valid is high in that cycle.
- in_ready returns to 1 at T+W+2.
- Throughput: one conversion per W+2 cycles. For W=16: 18 cycles, latency 17.
- in_ready is a pure decode of state (registered); it has no combinational path from in_valid.
- digits, blank and out_valid are registered outputs.

## Test plan

- Reset for 2 cycles, check during reset and first cycle after:
  - During reset: in_ready=0.
  - First cycle after: in_ready=1, digits=0x00000, blank=5'b11110, out_valid=0.
- in_data=0 handshake at T:
  - out_valid only at T+17.
  - digits=0x00000, blank=5'b11110.
- in_data=65535 (0xFFFF):
  - digits=0x65535, blank=5'b00000.
- in_data=1234:
  - digits=0x01234, blank=5'b10000.
- in_data=1234, then in_data=9 presented at T+5 (ignored), then 100 on the next accepted handshake:
  - First result is 0x01234.
  - in_ready is low from T+1 to T+17.
  - Second result is digits=0x00100, blank=5'b11000.
- Start 65535, assert reset at T+8 for 1 cycle:
  - No out_valid pulse.
  - digits=0, blank=5'b11110.
  - in_ready=1 at T+9.
  - A following 42 converts to 0x00042.
